mux4_arbiter: RTL

MUX4_ARBITER -- requirements
Module: mux4_arbiter

---
 rtl/mux4_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mux4_arbiter.sv
// Four-requester round-robin arbiter driving a 4:1 mux select, with a one-cycle
// break-before-make gap between owners. Define MUX4ARB_HOLDLIMIT_EN to cap tenure at MAXHOLD.
module mux4_arbiter #(
    parameter int MAXHOLD = 8
) (
    input  logic       clk,
    input  logic       CROBAR,
    input  logic [0:3] REQ,
    output logic [0:3] GRANT,
    output logic [0:1] SEL,
    output logic       EN,
    output logic       BUSY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    if (MAXHOLD < 2 || MAXHOLD > 255) begin : g_maxhold_range
        $error("mux4_arbiter: MAXHOLD must be in 2..255");
    end

    state_t     state;
    state_t     nxt_state;
    logic [1:0] last;
    logic [1:0] nxt_last;
    logic [0:3] nxt_grant;
    logic [0:1] nxt_sel;
    logic       nxt_en;

    logic       win_found;
    logic [1:0] win_idx;
    logic       force_release;
    logic       owner_keeps;

    // Rotating priority: scan last+1 .. last+4 (mod 4); the lowest offset that
    // requests wins, so the loop runs backwards and the final hit overwrites.
    always_comb begin
        logic [1:0] cand;
        win_found = 1'b0;
        win_idx   = last;
        cand      = last;
        for (int k = 4; k >= 1; k--) begin
            cand = last + 2'(k);
            if (REQ[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

`ifdef MUX4ARB_HOLDLIMIT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAXHOLD - 1);

    logic [7:0] hold_cnt;
    logic [7:0] nxt_hold_cnt;
    logic [0:3] owner_mask;

    always_comb begin
        owner_mask       = '0;
        owner_mask[last] = 1'b1;
    end

    assign force_release = (hold_cnt == HOLD_LAST) && (|(REQ & ~owner_mask));

    // Held at zero outside OWN, so it starts from zero on every new tenure.
    always_comb begin
        nxt_hold_cnt = hold_cnt;
        if (state != OWN) begin
            nxt_hold_cnt = '0;
        end else if (hold_cnt != HOLD_LAST) begin
            nxt_hold_cnt = hold_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (CROBAR) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= nxt_hold_cnt;
        end
    end
`else
    assign force_release = 1'b0;
`endif

    assign owner_keeps = REQ[last] && !force_release;

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; a missed default would infer a latch.
    always_comb begin
        nxt_state = state;
        nxt_last  = last;
        nxt_grant = '0;
        nxt_sel   = SEL;
        nxt_en    = 1'b0;

        unique case (state)
            IDLE, GAP: begin
                if (win_found) begin
                    nxt_state          = OWN;
                    nxt_last           = win_idx;
                    nxt_grant[win_idx] = 1'b1;
                    nxt_sel            = win_idx;
                    nxt_en             = 1'b1;
                end else begin
                    nxt_state = IDLE;
                end
            end
            OWN: begin
                if (owner_keeps) begin
                    nxt_grant = GRANT;
                    nxt_en    = 1'b1;
                end else begin
                    nxt_state = GAP;
                end
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (CROBAR) begin
            state <= IDLE;
            last  <= 2'd3;
            GRANT <= '0;
            SEL   <= '0;
            EN    <= 1'b0;
            BUSY  <= 1'b0;
        end else begin
            state <= nxt_state;
            last  <= nxt_last;
            GRANT <= nxt_grant;
            SEL   <= nxt_sel;
            EN    <= nxt_en;
            BUSY  <= (nxt_state != IDLE);
        end
    end

endmodule
